// File: rtl/clk_div_pkg.sv
// Purpose: shared constants, per-channel status type and helpers for the clock divider.
// Latency: none; this file holds compile-time items only.
// Backpressure: none.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF  = 28;
  localparam int unsigned CLK_HZ     = 100_000_000;

  // Half-period constants for the legacy fixed divider rates.
  localparam int unsigned HALF_1HZ   = 50_000_000;
  localparam int unsigned HALF_10HZ  = 5_000_000;
  localparam int unsigned HALF_381HZ = 131_072;  // 2^17 -> 381.47 Hz

  // Registered per-channel outputs, grouped so the top can fan them out.
  typedef struct packed {
    logic clk;      // square-wave output
    logic tick;     // one-cycle pulse on the 0->1 edge of clk
    logic pending;  // an update is waiting for this channel's next wrap
  } ch_stat_t;

  // Half-period in system clock cycles for a target output frequency.
  function automatic int unsigned hz_to_half(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// Purpose: one divider channel - half-period counter, toggle, tick, pending update.
// Latency: clk/tick registered; an accepted update applies at the next wrap (next cycle if halted).
// Backpressure: none here; the top only issues load while this channel has nothing pending.
//
// Ports:
//   clk100mhz  system clock
//   rst        asynchronous active-high reset
//   load       cfg transfer targeting this channel (one cycle)
//   load_half  half-period carried by that transfer
//   align      force cnt/clk to zero and apply any pending/accepted update
//   stat       registered clk, tick and pending flag
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] HALF_INIT = CNT_W'(HALF_1HZ)
) (
  input  logic             clk100mhz,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_half,
  input  logic             align,
  output ch_stat_t         stat
);

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_half;
  logic             clk_q;
  logic             tick_q;
  logic             pending;

  logic             halted;
  logic             wrap;
  logic             apply_now;

  assign halted    = (half == '0);
  assign wrap      = !halted && (cnt == half - CNT_W'(1));
  // A halted channel has no wrap to wait for, so it takes the update at once.
  assign apply_now = pending && (wrap || halted);

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      half      <= HALF_INIT;
      cnt       <= '0;
      pend_half <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      pending   <= 1'b0;
    end else if (align) begin
      // Alignment wins over a wrap; a transfer in the same cycle lands directly.
      cnt     <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      pending <= 1'b0;
      if (load) begin
        half <= load_half;
      end else if (pending) begin
        half <= pend_half;
      end
    end else begin
      tick_q <= 1'b0;

      if (halted) begin
        cnt   <= '0;
        clk_q <= 1'b0;
      end else if (wrap) begin
        cnt <= '0;
        if (apply_now && (pend_half == '0)) begin
          // Halting update: park low, and suppress the rise this wrap would make.
          clk_q <= 1'b0;
        end else begin
          clk_q  <= ~clk_q;
          tick_q <= ~clk_q;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // The new half only governs counting after this edge, so the wrap above
      // still used the old one.
      if (apply_now) begin
        half    <= pend_half;
        pending <= 1'b0;
      end

      // load only arrives while nothing is pending, so it never collides with apply.
      if (load) begin
        pending   <= 1'b1;
        pend_half <= load_half;
      end
    end
  end

  assign stat = '{clk: clk_q, tick: tick_q, pending: pending};

endmodule

// File: rtl/clk_div_multi.sv
// Purpose: N_CH independent 50%-duty clock/tick generators with run-time reprogramming.
// Latency: outputs registered; updates apply at target's next wrap (<= one half-period).
// Backpressure: cfg_ready low while any channel holds a pending update (one outstanding).
//
// Ports:
//   clk100mhz            system clock (only clock)
//   rst                  asynchronous active-high reset
//   cfg_valid/cfg_ready  reconfiguration handshake
//   cfg_ch, cfg_half     target channel and new half-period (cfg_ch >= N_CH is dropped)
//   align                phase-align pulse, present only with CLKDIV_PHASE_ALIGN_EN
//   clk_out, tick        per-channel square wave and rise-aligned tick
//
// Build option: define CLKDIV_PHASE_ALIGN_EN to add the align port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int                    N_CH     = 3,
  parameter int                    CNT_W    = CNT_W_DEF,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {28'(HALF_1HZ), 28'(HALF_10HZ), 28'(HALF_381HZ)},
  localparam int                   CH_W     = ch_w(N_CH)
) (
  input  logic             clk100mhz,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
`ifdef CLKDIV_PHASE_ALIGN_EN
  input  logic             align,
`endif
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  ch_stat_t        stat [N_CH];
  logic [N_CH-1:0] pend_vec;
  logic [N_CH-1:0] load_vec;
  logic            cfg_xfer;
  logic            align_int;

`ifdef CLKDIV_PHASE_ALIGN_EN
  assign align_int = align;
`else
  assign align_int = 1'b0;
`endif

  // Only one pending flag can be set at a time, so this OR of flops cannot glitch.
  assign cfg_ready = ~|pend_vec;
  assign cfg_xfer  = cfg_valid && cfg_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no instance and are silently dropped.
    assign load_vec[i] = cfg_xfer && (cfg_ch == CH_W'(i));

    clk_div_ch #(
      .CNT_W     (CNT_W),
      .HALF_INIT (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk100mhz (clk100mhz),
      .rst       (rst),
      .load      (load_vec[i]),
      .load_half (cfg_half),
      .align     (align_int),
      .stat      (stat[i])
    );

    assign clk_out[i]  = stat[i].clk;
    assign tick[i]     = stat[i].tick;
    assign pend_vec[i] = stat[i].pending;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  logic       clk100mhz = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_half;
  logic [2:0] clk_out;
  logic [2:0] tick;
`ifdef CLKDIV_PHASE_ALIGN_EN
  logic       align;
`endif

  always #5 clk100mhz = ~clk100mhz;

  clk_div_multi #(
    .N_CH     (3),
    .CNT_W    (8),
    .DIV_INIT ({8'd3, 8'd2, 8'd1})
  ) dut (
    .clk100mhz (clk100mhz),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
`ifdef CLKDIV_PHASE_ALIGN_EN
    .align     (align),
`endif
    .clk_out   (clk_out),
    .tick      (tick)
  );

  typedef struct {
    logic [2:0] clk;
    logic [2:0] tk;
    logic       rdy;
  } vec_t;

  vec_t tbl [13];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_half  = 8'd0;
`ifdef CLKDIV_PHASE_ALIGN_EN
    align     = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
  endtask

  // Row k = state after edge k following reset release (row 0 = before edge 1).
  task automatic run_table(input string tag);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) step();
      chk($sformatf("%s clk_out k%0d", tag, k), 32'(clk_out), 32'(tbl[k].clk));
      chk($sformatf("%s tick k%0d", tag, k), 32'(tick), 32'(tbl[k].tk));
      chk($sformatf("%s cfg_ready k%0d", tag, k), 32'(cfg_ready), 32'(tbl[k].rdy));
    end
  endtask

  task automatic cfg_req(input logic [1:0] ch, input logic [7:0] h);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_half  = h;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    chk(name, 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // DIV_INIT = {3,2,1}: ch0 rises at odd edges, ch1 at 2,6,10, ch2 at 3,9.
    tbl[0]  = '{clk: 3'b000, tk: 3'b000, rdy: 1'b1};
    tbl[1]  = '{clk: 3'b001, tk: 3'b001, rdy: 1'b1};
    tbl[2]  = '{clk: 3'b010, tk: 3'b010, rdy: 1'b1};
    tbl[3]  = '{clk: 3'b111, tk: 3'b101, rdy: 1'b1};
    tbl[4]  = '{clk: 3'b100, tk: 3'b000, rdy: 1'b1};
    tbl[5]  = '{clk: 3'b101, tk: 3'b001, rdy: 1'b1};
    tbl[6]  = '{clk: 3'b010, tk: 3'b010, rdy: 1'b1};
    tbl[7]  = '{clk: 3'b011, tk: 3'b001, rdy: 1'b1};
    tbl[8]  = '{clk: 3'b000, tk: 3'b000, rdy: 1'b1};
    tbl[9]  = '{clk: 3'b101, tk: 3'b101, rdy: 1'b1};
    tbl[10] = '{clk: 3'b110, tk: 3'b010, rdy: 1'b1};
    tbl[11] = '{clk: 3'b111, tk: 3'b001, rdy: 1'b1};
    tbl[12] = '{clk: 3'b000, tk: 3'b000, rdy: 1'b1};

    // Reset release timing, with a stream of out-of-range requests that must be dropped.
    do_reset();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_half  = 8'd7;
    run_table("init");
    cfg_valid = 1'b0;

    // Reprogram ch2 3 -> 5 during its high phase.
    do_reset();
    repeat (3) step();
    chk("A ch2 high before req", 32'(clk_out[2]), 32'd1);
    cfg_req(2'd2, 8'd5);                             // transfer at edge 4
    chk("A rdy low after xfer", 32'(cfg_ready), 32'd0);
    step();                                          // edge 5
    chk("A rdy low pending", 32'(cfg_ready), 32'd0);
    chk("A ch2 still high", 32'(clk_out[2]), 32'd1);
    step();                                          // edge 6: wrap + apply
    chk("A ch2 falls at wrap", 32'(clk_out[2]), 32'd0);
    chk("A rdy back after apply", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("A ch2 low %0d", i), 32'({clk_out[2], tick[2]}), 32'd0);
    end
    step();                                          // edge 11
    chk("A ch2 rise after 5 low", 32'({clk_out[2], tick[2]}), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("A ch2 high %0d", i), 32'({clk_out[2], tick[2]}), 32'd2);
    end
    step();                                          // edge 16
    chk("A ch2 fall after 5 high", 32'(clk_out[2]), 32'd0);

    // Halt ch1 with half=0 while low, then restart with half=2.
    do_reset();
    repeat (4) step();
    chk("B ch1 low before req", 32'(clk_out[1]), 32'd0);
    cfg_req(2'd1, 8'd0);                             // transfer at edge 5
    chk("B rdy low after xfer", 32'(cfg_ready), 32'd0);
    step();                                          // edge 6: wrap, rise suppressed
    chk("B ch1 no rise at halt", 32'({clk_out[1], tick[1]}), 32'd0);
    chk("B rdy back after halt", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("B ch1 halted %0d", i), 32'({clk_out[1], tick[1]}), 32'd0);
    end
    cfg_req(2'd1, 8'd2);                             // transfer at edge 15
    chk("B rdy low restart", 32'(cfg_ready), 32'd0);
    step();                                          // edge 16: apply while halted
    chk("B rdy back restart", 32'(cfg_ready), 32'd1);
    chk("B ch1 low at apply", 32'(clk_out[1]), 32'd0);
    step();
    chk("B ch1 low apply+1", 32'(clk_out[1]), 32'd0);
    step();
    chk("B ch1 rise apply+2", 32'({clk_out[1], tick[1]}), 32'd3);
    step();
    chk("B ch1 high apply+3", 32'({clk_out[1], tick[1]}), 32'd2);
    step();
    chk("B ch1 fall apply+4", 32'(clk_out[1]), 32'd0);

    // Reset while an update is pending: immediate clear, original timing resumes.
    do_reset();
    repeat (3) step();
    cfg_req(2'd2, 8'd5);                             // transfer at edge 4
    chk("D rdy low pending", 32'(cfg_ready), 32'd0);
    chk("D clk before reset", 32'(clk_out), 32'b100);
    rst = 1'b1;
    #1;
    chk("D async clk_out", 32'(clk_out), 32'd0);
    chk("D async tick", 32'(tick), 32'd0);
    chk("D async rdy", 32'(cfg_ready), 32'd1);
    step();
    rst = 1'b0;
    run_table("post");

`ifdef CLKDIV_PHASE_ALIGN_EN
    // Bring channels out of phase, then align with a same-cycle update of ch2.
    do_reset();
    cfg_req(2'd0, 8'd4);
    wait_rdy("E ch0 update applied");
    cfg_req(2'd1, 8'd4);
    wait_rdy("E ch1 update applied");
    repeat (3) step();
    align     = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_half  = 8'd4;
    step();                                          // align edge
    align     = 1'b0;
    cfg_valid = 1'b0;
    chk("E clk zero after align", 32'(clk_out), 32'd0);
    chk("E tick zero after align", 32'(tick), 32'd0);
    chk("E rdy after align", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("E all low %0d", i), 32'(clk_out), 32'd0);
    end
    step();
    chk("E all rise clk", 32'(clk_out), 32'b111);
    chk("E all rise tick", 32'(tick), 32'b111);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("E all high %0d", i), 32'({clk_out, tick}), 32'b111000);
    end
    step();
    chk("E all fall", 32'(clk_out), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider and tick generator: the next generation of the fixed 380 Hz / 10 Hz / 1 Hz divider. N_CH independent channels each produce a 50 %-duty square wave plus a one-cycle tick (clock-enable) per output period, all from the 100 MHz system clock. Each channel's half-period is loaded from a parameter at reset and is reprogrammable at run time through a valid/ready port. Updates apply glitch-free at the channel's next wrap. The block sits at the top of the design and feeds display scanning, key debouncing and the 1 Hz elevator timebase.

## Interface
Parameters:
- N_CH, default 3: number of channels (1..16).
- CNT_W, default 28: half-period counter width.
- DIV_INIT, default {28'd50_000_000, 28'd5_000_000, 28'd131_072}: packed N_CH*CNT_W vector of reset half-periods. Channel 0 occupies the LSBs, so the defaults are ch0 ≈ 381 Hz, ch1 = 10 Hz, ch2 = 1 Hz.

Ports:
- clk100mhz, in, 1: system clock, 100 MHz. This is the only clock.
- rst, in, 1: asynchronous reset, active-high.
- cfg_valid, in, 1: a reconfiguration request is present.
- cfg_ready, out, 1: the block can accept a request.
- cfg_ch, in, CH_W = max(1, $clog2(N_CH)): target channel.
- cfg_half, in, CNT_W: new half-period in clk100mhz cycles.
- align, in, 1: phase-align pulse. Present only with CLKDIV_PHASE_ALIGN_EN.
- clk_out, out, N_CH: square-wave outputs.
- tick, out, N_CH: one-cycle pulse per output period.

## Operation
- Per-channel state: half register, counter cnt, output bit clk_out, pending flag, and pend_half.
- Run (half ≥ 1):
  - Each cycle, if cnt == half−1 the channel wraps: cnt←0 and clk_out toggles. Otherwise cnt←cnt+1.
  - tick[i] is 1 exactly in the cycle where clk_out[i] goes 0→1.
- Halted (half == 0): cnt held at 0, clk_out held 0, tick held 0.
- half == 1 gives clk100mhz/2; clk_out toggles every cycle and tick pulses every second cycle.
- Config handshake:
  - Transfer occurs on a rising edge with cfg_valid && cfg_ready.
  - After a transfer, cfg_ready drops the following cycle. It stays low while the target's pending flag is set, so only one update is outstanding at a time.
  - The pending value is applied at the target's next wrap, or on the next cycle if the target is halted. On apply: half←pend_half, pending cleared, cfg_ready high again the next cycle.
  - At the wrap where the update applies, the toggle still happens. The new half governs the very next count.
  - A request with cfg_ch ≥ N_CH is accepted and discarded; cfg_ready stays high.
  - Loading 0 halts the channel at that wrap. At that point clk_out is forced 0, with no tick.
- Requesters must hold cfg_valid/cfg_ch/cfg_half stable until the transfer occurs.

## Timing
- Reset values: cnt=0, clk_out=0, tick=0, half=DIV_INIT slice, pending=0, cfg_ready=1.
- After rst deasserts, with constant half H: clk_out[i] first rises at clock edge H, with tick high in that same cycle. The output period is then exactly 2H cycles, with H high and H low.
- tick and clk_out are registered and change on the same edge. There are no combinational paths from inputs to outputs.
- Reset asserted mid-period or mid-update returns all state to reset values immediately (asynchronously). The pending update is lost.
- Worst-case config latency is one full half-period of the target channel.

## Configuration
- CLKDIV_PHASE_ALIGN_EN defined:
  - The align input exists.
  - The cycle after align=1, every channel has cnt=0 and clk_out=0, with no tick in that cycle.
  - Any pending update is applied at that edge, and cfg_ready returns high.
  - align has priority over a wrap in the same cycle. A cfg transfer in the same cycle is accepted and applied by the alignment.
- Not defined: no align port, and channels free-run from reset only.

## Structure
- Package clk_div_pkg holds:
  - CNT_W_DEF = 28 and CLK_HZ = 100_000_000.
  - Half-period constants HALF_1HZ = 50_000_000, HALF_10HZ = 5_000_000, HALF_381HZ = 131_072.
  - A function hz_to_half(hz) = CLK_HZ/(2*hz).
- Sub-module clk_div_ch implements one channel: counter, toggle, tick, pending register and apply logic. The top generates N_CH instances and holds the shared cfg_ready/arbitration logic.

## Test plan
- Reset release, DIV_INIT={3,2,1}:
  - ch0 rises at edge 1, period 2.
  - ch1 rises at edge 2, period 4.
  - ch2 rises at edge 3, period 6.
  - Each tick is one cycle per period and coincides with the rise.
- Reprogram ch2 from 3 to 5 mid-high-phase: cfg_ready goes low. At the wrap, clk_out falls and the next low phase lasts 5 cycles. cfg_ready returns high one cycle after the wrap.
- Load half=0 on ch1: ch1 holds clk_out=0 and tick=0 from that wrap. Loading 2 afterwards restarts it, with a first rise 2 cycles after the apply.
- cfg_ch=3 with N_CH=3: the request is accepted, cfg_ready stays high, and no channel changes.
- Assert rst mid-pending: all outputs return to 0 and cfg_ready=1 immediately, and the old DIV_INIT timing resumes.
- With CLKDIV_PHASE_ALIGN_EN, pulse align while channels are out of phase: the next cycle all clk_out=0 and cnt=0. Afterwards all channels rise together at edge H after the align edge when their H values are equal.
